// File: rtl/bmu_pkg.sv
// Shared types and constants for the BMU issue path.
// Decode encodings, issue-queue depth and queue entry layout.
package bmu_pkg;

  localparam int QUEUE_DEPTH = 4;
  localparam int PTR_W       = 2;
  localparam int CNT_W       = 3;

  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRA = 3'b101;

  typedef struct packed {
    logic zbb;
    logic land;
    logic lxor;
    logic sll;
    logic sra;
  } ap_struct;

  typedef struct packed {
    ap_struct    ap;
    logic [31:0] a;
    logic [31:0] b;
    logic        csr_ren;
    logic [31:0] csr_rdata;
  } entry_t;

endpackage

// File: rtl/bmu_inst_decoder.sv
// Combinational RV32 decoder for the BMU subset.
// Reports op flags, immediate select/value and legality.
module bmu_inst_decoder
  import bmu_pkg::*;
(
  input  logic [31:0] instWord,
  output ap_struct    ap,
  output logic        bSel,
  output logic [31:0] imm,
  output logic        legal
);

  logic [6:0] w_op;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic       w_is_reg;
  logic       w_is_imm;

  assign w_op     = instWord[6:0];
  assign w_f3     = instWord[14:12];
  assign w_f7     = instWord[31:25];
  assign w_is_reg = (w_op == OP_REG);
  assign w_is_imm = (w_op == OP_IMM);

  always_comb begin
    ap    = '0;
    bSel  = 1'b0;
    imm   = '0;
    legal = 1'b0;
    unique case (1'b1)
      w_is_reg: begin
        legal = 1'b1;
        case ({w_f7, w_f3})
          {F7_BASE, F3_AND}: ap.land = 1'b1;
          {F7_BASE, F3_XOR}: ap.lxor = 1'b1;
          {F7_BASE, F3_SLL}: ap.sll  = 1'b1;
          {F7_ALT,  F3_SRA}: ap.sra  = 1'b1;
          {F7_ALT,  F3_AND}: begin
            ap.zbb  = 1'b1;
            ap.land = 1'b1;
          end
          {F7_ALT,  F3_XOR}: begin
            ap.zbb  = 1'b1;
            ap.lxor = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      w_is_imm: begin
        bSel  = 1'b1;
        legal = 1'b1;
        imm   = {{20{instWord[31]}}, instWord[31:20]};
        // Shifts take the zero-extended shamt, not the I-imm
        case (w_f3)
          F3_AND: ap.land = 1'b1;
          F3_XOR: ap.lxor = 1'b1;
          F3_SLL: begin
            ap.sll = 1'b1;
            imm    = {27'b0, instWord[24:20]};
            legal  = (w_f7 == F7_BASE);
          end
          F3_SRA: begin
            ap.sra = 1'b1;
            imm    = {27'b0, instWord[24:20]};
            legal  = (w_f7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/bmu_issue_stage.sv
// BMU issue stage: decode, 4-deep in-order queue,
// registered one-per-cycle issue to the BMU.
module bmu_issue_stage
  import bmu_pkg::*;
(
  input  logic        clk,
  input  logic        rstL,
  input  logic        scanMode,
  input  logic        flush,
  input  logic        instValid,
  output logic        instReady,
  input  logic [31:0] instWord,
  input  logic [31:0] rs1Data,
  input  logic [31:0] rs2Data,
  input  logic        csrRen,
  input  logic [31:0] csrRdata,
  output logic        validIn,
  output logic [4:0]  ap,
  output logic        csrRenIn,
  output logic [31:0] csrRdataIn,
  output logic [31:0] aIn,
  output logic [31:0] bIn,
  output logic        illegal,
  output logic [2:0]  occupancy
);

  ap_struct    w_ap;
  logic        w_bsel;
  logic [31:0] w_imm;
  logic        w_legal;
  logic        w_acc;
  logic        w_enq;
  logic        w_deq;
  entry_t      w_ent;
  entry_t      w_head;

  entry_t           r_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  ap_struct         r_ap;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_cren;
  logic [31:0]      r_crd;
  logic             r_ill;

  bmu_inst_decoder u_dec (
    .instWord (instWord),
    .ap       (w_ap),
    .bSel     (w_bsel),
    .imm      (w_imm),
    .legal    (w_legal)
  );

  assign instReady = (r_cnt != CNT_W'(QUEUE_DEPTH));
  assign w_acc     = instValid && instReady && !flush;
  assign w_enq     = w_acc && w_legal;
  assign w_deq     = (r_cnt != '0) && !scanMode && !flush;

  assign w_ent.ap        = w_ap;
  assign w_ent.a         = rs1Data;
  assign w_ent.b         = w_bsel ? w_imm : rs2Data;
  assign w_ent.csr_ren   = csrRen;
  assign w_ent.csr_rdata = csrRdata;
  assign w_head          = r_q[r_rp];

  // Payload storage needs no reset; validity lives in r_cnt
  always_ff @(posedge clk) begin
    if (w_enq) r_q[r_wp] <= w_ent;
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_ap    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cren  <= 1'b0;
      r_crd   <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_ill   <= w_acc && !w_legal;
      r_valid <= w_deq;
      r_cren  <= w_deq && w_head.csr_ren;
      if (flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_enq) r_wp <= r_wp + 1'b1;
        if (w_deq) r_rp <= r_rp + 1'b1;
        if (w_enq && !w_deq) r_cnt <= r_cnt + 1'b1;
        if (!w_enq && w_deq) r_cnt <= r_cnt - 1'b1;
      end
      if (w_deq) begin
        r_ap  <= w_head.ap;
        r_a   <= w_head.a;
        r_b   <= w_head.b;
        r_crd <= w_head.csr_rdata;
      end
    end
  end

  assign validIn    = r_valid;
  assign ap         = r_ap;
  assign aIn        = r_a;
  assign bIn        = r_b;
  assign csrRenIn   = r_cren;
  assign csrRdataIn = r_crd;
  assign illegal    = r_ill;
  assign occupancy  = r_cnt;

endmodule

// File: doc/bmu_issue_stage.md
BMU_ISSUE_STAGE -- requirements
Module: bmu_issue_stage

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk (1-bit input), rstL (1-bit input); no other clock or reset.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock; all state on rising edge.
- rstL  in  1  async active-low reset.
- scanMode  in  1  1 = freeze issue; enqueue still allowed.
- flush  in  1  sync clear of queue and issue register.
- instValid  in  1  upstream request valid.
- instReady  out  1  queue can accept; = !full.
- instWord  in  32  RV32 instruction.
- rs1Data  in  32  source operand 1.
- rs2Data  in  32  source operand 2.
- csrRen  in  1  CSR read accompanies request.
- csrRdata  in  32  CSR read data.
- validIn  out  1  issue strobe to BMU, registered.
- ap  out  5  packed {zbb, land, lxor, sll, sra}, registered.
- csrRenIn  out  1  registered CSR read enable.
- csrRdataIn  out  32  registered CSR data.
- aIn  out  32  registered operand A.
- bIn  out  32  registered operand B.
- illegal  out  1  one-cycle pulse: undecodable instruction dropped.
- occupancy  out  3  queue entries, 0..4.

Function
REQ-003 SHALL accept a request on a rising edge where instValid && instReady.
REQ-004 SHALL decode opcode 0110011 (funct7, funct3) as follows, with bIn = rs2Data:
- AND (0000000, 111) -> land.
- XOR (0000000, 100) -> lxor.
- SLL (0000000, 001) -> sll.
- SRA (0100000, 101) -> sra.
- ANDN (0100000, 111) -> zbb+land.
- XNOR (0100000, 100) -> zbb+lxor.
REQ-005 SHALL decode opcode 0010011 as follows:
- ANDI (111) -> land, bIn = sign-extended imm[11:0].
- XORI (100) -> lxor, bIn = sign-extended imm[11:0].
- SLLI (001, imm[11:5] = 0000000) -> sll, bIn = zero-extended shamt[4:0].
- SRAI (101, imm[11:5] = 0100000) -> sra, bIn = zero-extended shamt[4:0].
REQ-006 SHALL set aIn = rs1Data for every legal instruction.
REQ-007 SHALL treat any other encoding as illegal: the request is consumed, not enqueued, and illegal pulses high for exactly the next cycle.
REQ-008 SHALL store csrRen/csrRdata with the entry and present them on csrRenIn/csrRdataIn together with validIn.
REQ-009 SHALL buffer entries in a 4-deep FIFO, in order; instReady = (occupancy != 4), with no enqueue when full even if a dequeue occurs in the same cycle.
REQ-010 SHALL dequeue one entry per cycle when occupancy > 0 and scanMode = 0, registering it onto the BMU outputs with validIn = 1 for exactly one cycle per entry.
REQ-011 SHALL set validIn = 0 when nothing is dequeued; when validIn = 0, ap, aIn, bIn, csrRdataIn hold their previous values and csrRenIn = 0.
REQ-012 SHALL give a minimum latency of one cycle: a request accepted at edge N into an empty queue drives validIn high from edge N+1.
REQ-013 SHALL allow enqueue and dequeue in the same cycle, leaving occupancy unchanged.
REQ-014 SHALL have flush take priority over enqueue and dequeue: on the flush edge occupancy -> 0, the same-cycle request is dropped, validIn -> 0 next cycle, and illegal is not asserted for the dropped request.
REQ-015 SHALL let read/write pointers wrap modulo 4 with no bubble.

Reset
REQ-016 SHALL, while rstL = 0, force occupancy = 0, pointers = 0, validIn = 0, ap = 0, aIn = 0, bIn = 0, csrRenIn = 0, csrRdataIn = 0, illegal = 0; instReady = 1 after reset.
REQ-017 SHALL discard any queued entries when reset is asserted mid-operation; no issue occurs in the first cycle after release unless a request was enqueued.

Structure
REQ-018 SHALL take the ap_struct typedef, the opcode/funct constants and QUEUE_DEPTH = 4 from shared package bmu_pkg.
REQ-019 SHALL place decoding in combinational sub-module bmu_inst_decoder (outputs ap, bSel/imm, legal).

Verification
REQ-020 SHALL cover: reset; then AND with rs1 = 0xF0F0F0F0, rs2 = 0x0FF0FF00 -> next cycle validIn = 1, ap = land, aIn = 0xF0F0F0F0, bIn = 0x0FF0FF00.
REQ-021 SHALL cover: SRAI shamt = 5, then ANDI imm = 0x800 back-to-back -> bIn = 0x00000005, then bIn = 0xFFFFF800, on consecutive cycles.
REQ-022 SHALL cover: scanMode = 1 with 5 valid requests -> 4 accepted, instReady = 0, occupancy = 4; scanMode -> 0 gives 4 consecutive validIn pulses in order.
REQ-023 SHALL cover: instWord = 0x00000000 -> illegal pulses for one cycle, occupancy unchanged, no validIn.
REQ-024 SHALL cover: flush while occupancy = 3 with a concurrent valid request -> occupancy = 0 next cycle, and no validIn follows.
REQ-025 SHALL cover: XNOR with csrRen = 1, csrRdata = 0x12345678 -> ap = zbb+lxor, csrRenIn = 1, csrRdataIn = 0x12345678.
